uart_tx_arbiter: RTL

Round-robin scheduler that shares one UART transmit unit between NUM_REQ byte producers.
- Picks one requester and latches its byte, parity type and baud rate.
- Launches the Tx unit with a one-cycle start pulse and holds ownership until the Tx reports frame completion.
- Sits between the producers and the Tx unit. Configuration codes are the same ones the Rx unit uses.

---
 rtl/uart_tx_arbiter_if.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Request bus from the byte producers plus the handshake to the shared UART Tx unit.
// slave is the arbiter's view; master is the producer/Tx-unit side.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [2*NUM_REQ-1:0] req_parity;
  logic [2*NUM_REQ-1:0] req_baud;
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   done;
  logic                 busy;
  logic [2:0]           owner;
  logic                 tx_send;
  logic [7:0]           tx_data;
  logic [1:0]           tx_parity_type;
  logic [1:0]           tx_baud_rate;
  logic                 tx_active;
  logic                 tx_done;
  logic                 timeout_err;

  modport master (
    output req, req_data, req_parity, req_baud, tx_active, tx_done,
    input  grant, done, busy, owner, tx_send, tx_data, tx_parity_type,
           tx_baud_rate, timeout_err
  );

  modport slave (
    input  req, req_data, req_parity, req_baud, tx_active, tx_done,
    output grant, done, busy, owner, tx_send, tx_data, tx_parity_type,
           tx_baud_rate, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART Tx unit between NUM_REQ byte producers.
// Optional frame watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 262144
) (
  input logic              clock,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES at least 2");
  end

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    START       = 2'd1,
    WAIT_ACTIVE = 2'd2,
    WAIT_DONE   = 2'd3
  } state_t;

  state_t             state_q, state_n;
  logic [IDX_W-1:0]   ptr_q, ptr_n;
  logic [IDX_W-1:0]   owner_q, owner_n;
  logic [IDX_W-1:0]   owner_inc;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_valid;
  int unsigned        cand;
  logic [NUM_REQ-1:0] grant_q, grant_n;
  logic [NUM_REQ-1:0] done_q, done_n;
  logic               busy_q;
  logic               tx_send_q, tx_send_n;
  logic               timeout_err_q, timeout_err_n;
  logic [7:0]         data_q, data_n;
  logic [1:0]         parity_q, parity_n;
  logic [1:0]         baud_q, baud_n;
  logic               timeout_hit;

  // First pending request at or after the pointer, wrapping around.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!sel_valid && bus.req[IDX_W'(cand)]) begin
        sel_valid = 1'b1;
        sel_idx   = IDX_W'(cand);
      end
    end
  end

  assign owner_inc = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES) > 18) ? $clog2(TIMEOUT_CYCLES) : 18;

  logic [CNT_W-1:0] cnt_q;

  // Frame watchdog: zeroed while launching, counts while waiting on the Tx unit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state_q == START) begin
      cnt_q <= '0;
    end else if (state_q == WAIT_ACTIVE || state_q == WAIT_DONE) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and next-output logic; outputs are registered below.
  always_comb begin
    state_n       = state_q;
    ptr_n         = ptr_q;
    owner_n       = owner_q;
    data_n        = data_q;
    parity_n      = parity_q;
    baud_n        = baud_q;
    grant_n       = '0;
    done_n        = '0;
    tx_send_n     = 1'b0;
    timeout_err_n = 1'b0;

    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          owner_n          = sel_idx;
          data_n           = bus.req_data[{sel_idx, 3'b000} +: 8];
          parity_n         = bus.req_parity[{sel_idx, 1'b0} +: 2];
          baud_n           = bus.req_baud[{sel_idx, 1'b0} +: 2];
          grant_n[sel_idx] = 1'b1;
          state_n          = START;
        end
      end

      START: begin
        tx_send_n = 1'b1;
        state_n   = WAIT_ACTIVE;
      end

      WAIT_ACTIVE, WAIT_DONE: begin
        // tx_done outranks both tx_active and an expiring watchdog.
        if (bus.tx_done) begin
          done_n[owner_q] = 1'b1;
          ptr_n           = owner_inc;
          state_n         = IDLE;
        end else if (timeout_hit) begin
          timeout_err_n = 1'b1;
          ptr_n         = owner_inc;
          state_n       = IDLE;
        end else if (state_q == WAIT_ACTIVE && bus.tx_active) begin
          state_n = WAIT_DONE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      owner_q       <= '0;
      data_q        <= '0;
      parity_q      <= '0;
      baud_q        <= '0;
      grant_q       <= '0;
      done_q        <= '0;
      busy_q        <= 1'b0;
      tx_send_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_n;
      ptr_q         <= ptr_n;
      owner_q       <= owner_n;
      data_q        <= data_n;
      parity_q      <= parity_n;
      baud_q        <= baud_n;
      grant_q       <= grant_n;
      done_q        <= done_n;
      busy_q        <= (state_n != IDLE);
      tx_send_q     <= tx_send_n;
      timeout_err_q <= timeout_err_n;
    end
  end

  assign bus.grant          = grant_q;
  assign bus.done           = done_q;
  assign bus.busy           = busy_q;
  assign bus.owner          = 3'(owner_q);
  assign bus.tx_send        = tx_send_q;
  assign bus.tx_data        = data_q;
  assign bus.tx_parity_type = parity_q;
  assign bus.tx_baud_rate   = baud_q;
  assign bus.timeout_err    = timeout_err_q;

endmodule
